// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a bank of seven-segment digits: one shared decoder, frame-synchronous
// updates, blanking, decimal points, guard time. Optional leading-zero suppression: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int DIGITS           = 4,
    parameter int PRESCALE         = 50000,
    parameter int GUARD            = 2,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = (DIGIT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   act_val, pend_val;
    logic [DIGITS-1:0]     act_dp, pend_dp;
    logic [DIGITS-1:0]     act_blank, pend_blank;
    logic                  pend_v;

    logic                  tick;
    logic                  boundary;
    logic                  in_guard;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_sup;
    logic [DIGITS-1:0]     sup;
    logic [DIGITS-1:0]     sel_hot;
    logic [7:0]            seg_nxt;
    logic [DIGITS-1:0]     sel_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h77;
            4'hB:    return 7'h1F;
            4'hC:    return 7'h4E;
            4'hD:    return 7'h3D;
            4'hE:    return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    assign tick     = (pcnt == PCNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign in_guard = (pcnt < PW'(GUARD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Transfer reads pending before this edge, so a load on the boundary waits one more frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_v     <= 1'b0;
        end else begin
            if (boundary && pend_v) begin
                act_val   <= pend_val;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank;
                pend_v     <= 1'b1;
            end else if (boundary) begin
                pend_v     <= 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit i is suppressed when it and every digit above it are zero; digit 0 is never suppressed.
    logic higher_zero;
    always_comb begin
        sup         = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero & (act_val[4*i +: 4] == 4'h0);
            sup[i]      = higher_zero;
        end
    end
`else
    assign sup = '0;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        sel_hot   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib    = act_val[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = act_blank[i];
                cur_sup    = sup[i];
                sel_hot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_nxt = 8'h00;
        sel_nxt = SEL_IDLE;
        if (!in_guard) begin
            sel_nxt = (DIGIT_ACTIVE_LOW != 0) ? ~sel_hot : sel_hot;
            if (!cur_blank) begin
                seg_nxt = {cur_dp, cur_sup ? 7'h00 : hex_to_seg(cur_nib)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= 8'h00;
            digit_sel  <= SEL_IDLE;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            digit_sel  <= sel_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int P = 4;
    localparam int G = 1;
    localparam int FRAME = D * P;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load = 1'b0;
    logic [15:0]     value = '0;
    logic [3:0]      dp_in = '0;
    logic [3:0]      blank = '0;
    logic [7:0]      seg_out;
    logic [3:0]      digit_sel;
    logic            frame_done;

    int checks = 0;
    int failures = 0;

    // Reference state: edges since reset release, plus the displayed/pending frame contents.
    int          k = 0;
    int          last_ph = 0;
    int          last_dg = 0;
    logic [15:0] m_aval = '0, m_pval = '0;
    logic [3:0]  m_adp = '0, m_pdp = '0, m_ablk = '0, m_pblk = '0;
    logic        m_pv = 1'b0;
    logic [6:0]  seg_lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_scan_driver #(
        .DIGITS(D), .PRESCALE(P), .GUARD(G), .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
        .seg_out(seg_out), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input int dg);
        int msd;
        logic [3:0] nib;
        msd = 0;
        for (int i = 0; i < D; i++)
            if (((m_aval >> (4 * i)) & 16'hF) != 0) msd = i;
        nib = 4'((m_aval >> (4 * dg)) & 16'hF);
        if (m_ablk[dg]) return 8'h00;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dg > msd) return {m_adp[dg], 7'h00};
`endif
        return {m_adp[dg], seg_lut[nib]};
    endfunction

    task automatic step();
        int ph, dg;
        logic bnd;
        logic [7:0] e_seg;
        logic [3:0] e_sel;
        @(posedge clk);
        ph  = k % P;
        dg  = (k / P) % D;
        bnd = (ph == P - 1) && (dg == D - 1);
        if (ph < G) begin
            e_seg = 8'h00;
            e_sel = 4'hF;
        end else begin
            e_seg = model_seg(dg);
            e_sel = ~(4'b0001 << dg);
        end
        if (bnd && m_pv) begin
            m_aval = m_pval; m_adp = m_pdp; m_ablk = m_pblk; m_pv = 1'b0;
        end
        if (load) begin
            m_pval = value; m_pdp = dp_in; m_pblk = blank; m_pv = 1'b1;
        end
        last_ph = ph;
        last_dg = dg;
        k++;
        @(negedge clk);
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("digit_sel", 32'(digit_sel), 32'(e_sel));
        check("frame_done", 32'(frame_done), 32'(bnd));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        load = 1'b1; value = v; dp_in = dp; blank = bl;
        step();
        load = 1'b0;
    endtask

    task automatic run_to_frame_start();
        while (k % FRAME != 0) step();
    endtask

    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int n = 0; n < FRAME; n++) begin
            step();
            if (last_ph == G) check($sformatf("frame_digit%0d", last_dg), 32'(seg_out), 32'(e[last_dg]));
        end
    endtask

    task automatic model_reset();
        k = 0; m_aval = '0; m_pval = '0; m_adp = '0; m_pdp = '0; m_ablk = '0; m_pblk = '0; m_pv = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_seg", 32'(seg_out), 32'h00);
        check("rst_sel", 32'(digit_sel), 32'hF);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Power-up frame: all zeros; frame_done first at the 16th edge.
        check_frame(8'h7E,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    8'h00, 8'h00, 8'h00);
`else
                    8'h7E, 8'h7E, 8'h7E);
`endif

        repeat (5) step();
        do_load(16'h12AF, 4'b0100, 4'b0000);
        run_to_frame_start();
        check_frame(8'h47, 8'h77, 8'hED, 8'h30);

        repeat (3) step();
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (4) step();
        do_load(16'h2222, 4'b0000, 4'b0000);
        run_to_frame_start();
        check_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);

        repeat (FRAME - 1) step();
        do_load(16'h8888, 4'b0000, 4'b1010);
        check_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);
        check_frame(8'h7F, 8'h00, 8'h7F, 8'h00);

        for (int i = 0; i < 600; i++) begin
            load  = (i >= 300 && i < 312) || ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        load = 1'b0;
        blank = '0;
        run_to_frame_start();

        repeat (FRAME - 3) step();
        do_load(16'h0050, 4'b0000, 4'b0000);
        run_to_frame_start();
        check_frame(8'h7E, 8'h5B,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    8'h00, 8'h00);
`else
                    8'h7E, 8'h7E);
`endif

        // Pending load then mid-slot reset on digit 2: pending must be discarded.
        repeat (3) step();
        do_load(16'h3333, 4'b1111, 4'b0000);
        while (k % FRAME != 2 * P + 2) step();
        #2 rst = 1'b1;
        #1;
        check("arst_seg", 32'(seg_out), 32'h00);
        check("arst_sel", 32'(digit_sel), 32'hF);
        check("arst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_frame(8'h7E,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    8'h00, 8'h00, 8'h00);
`else
                    8'h7E, 8'h7E, 8'h7E);
`endif
        check_frame(8'h7E,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    8'h00, 8'h00, 8'h00);
`else
                    8'h7E, 8'h7E, 8'h7E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode/common-cathode bank of DIGITS seven-segment digits, each showing a 4-bit hex nibble. Sits between the datapath that produces the display value and the board's segment/digit-select pins. It replaces per-digit combinational decoding with one shared decoder and a refresh scanner. It adds tear-free frame-synchronous updates, per-digit blanking, decimal points and anti-ghosting guard time.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; must be ≥ 2.
- PRESCALE, 50000: clk cycles per digit slot; must be > GUARD + 1.
- GUARD, 2: cycles at the start of each slot during which no digit is selected.
- DIGIT_ACTIVE_LOW, 1: 1 selects a digit with `digit_sel` bit = 0; 0 selects it with bit = 1.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe; captures `value`, `dp_in` and `blank` into the pending register.
- value  in  4*DIGITS  nibble i = value[4i+3:4i] = digit i; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank  in  DIGITS  1 = digit i fully dark, including its dp.
- seg_out  out  8  [7] = dp, [6:0] = a..g, active-high.
- digit_sel  out  DIGITS  one-hot digit enable, polarity per DIGIT_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. A slot tick occurs when pcnt == PRESCALE-1.
- Scan index `idx` is 0..DIGITS-1 and advances on each tick, wrapping DIGITS-1 → 0.
- Frame boundary: a tick with idx == DIGITS-1. On that cycle frame_done = 1, and if `pend_v` = 1 the active register takes the pending contents and `pend_v` clears.
- Load: the pending register takes value/dp_in/blank and `pend_v` is set. A second load before the boundary overwrites; only the last one is shown.
- Load on a boundary cycle: the transfer uses the pending contents from before the edge, the new data lands in pending, and `pend_v` stays 1, so it displays at the next boundary.
- Decoder, hex 0..F to a..g (bit6..bit0): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47. seg_out[7] = active dp bit.
- Blanked digit (active blank[idx] = 1): seg_out = 8'h00.
- Guard: while pcnt < GUARD, digit_sel is all inactive and seg_out = 8'h00. Otherwise exactly one digit_sel bit is active, for digit idx.

## Timing
- seg_out, digit_sel and frame_done are registered, with 1-cycle latency from the pcnt/idx state.
- Reset values (asynchronous): pcnt = 0, idx = 0, active and pending registers = 0, pend_v = 0, seg_out = 8'h00, digit_sel all inactive, frame_done = 0.
- After reset deassertion, digit 0 is first driven at cycle GUARD+1. Until the first load has passed a boundary, every digit shows 0 (7E).
- Slot length is exactly PRESCALE cycles; frame length is DIGITS*PRESCALE cycles.
- Mid-operation reset aborts immediately; the scan restarts at digit 0 and any pending load is discarded.
- `load` is level-sampled; holding it high reloads every cycle, which is legal.

## Configuration
- Macro: `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined: in the active register, digits above the most significant nonzero digit, or above digit 0 if the value is 0, are suppressed. Suppressed digits show seg_out[6:0] = 0, but the dp is still shown. Explicit `blank` still applies.
- Undefined: all non-blanked digits show their nibble, zeros included.

## Test plan
Config for all tests: DIGITS=4, PRESCALE=4, GUARD=1, DIGIT_ACTIVE_LOW=1.
- Reset release -> digit_sel = 4'b1111 and seg_out = 00 during guard; then digit_sel = 4'b1110 with seg_out = 7E. frame_done first pulses at cycle 16.
- load value = 16'h12AF, dp_in = 4'b0100 mid-frame -> display unchanged until frame_done. The next frame shows digit0 = 47, digit1 = 77, digit2 = ED (6D + dp), digit3 = 30.
- Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows only 6D on all digits.
- load 16'h8888 with blank = 4'b1010 on the boundary cycle -> the following frame shows the old value. The frame after shows 7F on digits 0 and 2 and 00 on digits 1 and 3.
- Macro defined, load 16'h0050 -> digit0 = 7E, digit1 = 5B, digits 2 and 3 = 00. Macro undefined -> digits 2 and 3 = 7E.
- Assert rst mid-slot on digit 2 -> outputs go to reset values asynchronously; after release the scan restarts at digit 0.
